// File: rtl/fc_input_layer.sv
// -----------------------------------------------------------------------------
// fc_input_layer
//   Serial-to-parallel front end for a fully connected layer. Words are popped
//   one at a time from an upstream first-word-fall-through FIFO and written into
//   consecutive slots of a LAYER_HEIGHT-word vector. Once every slot has been
//   written, the vector is presented on data_o with valid_o=1 and held until the
//   consumer accepts it with yumi_i. Words are passed through bit-exact.
//
// Parameters
//   LAYER_HEIGHT : words per assembled vector (>= 2)
//   WORD_SIZE    : bits per word
//
// Ports
//   clk_i    in   clock, rising edge
//   reset_i  in   synchronous active-high reset
//   data_i   in   FIFO head word, valid while empty_i=0
//   empty_i  in   FIFO empty flag
//   ren_o    out  FIFO pop strobe
//   data_o   out  assembled vector, meaningful while valid_o=1
//   valid_o  out  data_o holds a complete vector
//   yumi_i   in   consumer accepts data_o (only while valid_o=1)
//
// Build option
//   FC_INPUT_REVERSE_EN : when defined, the k-th popped word of a pass goes to
//                         data_o[LAYER_HEIGHT-1-k] instead of data_o[k].
//
// States
//   state | meaning
//   FILL  | popping words into slots, ren_o follows ~empty_i
//   FULL  | vector complete, valid_o=1, waiting for yumi_i
// -----------------------------------------------------------------------------
module fc_input_layer #(
    parameter int LAYER_HEIGHT = 13,
    parameter int WORD_SIZE    = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [WORD_SIZE-1:0]                   data_i,
    input  logic                                   empty_i,
    output logic                                   ren_o,
    output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o,
    output logic                                   valid_o,
    input  logic                                   yumi_i
);

    localparam int CNT_W = $clog2(LAYER_HEIGHT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAYER_HEIGHT - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                                 r_state;
    state_t                                 w_next_state;
    logic [CNT_W-1:0]                       r_count;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] r_data;
    logic                                   w_pop;
    logic                                   w_last;
    logic [CNT_W-1:0]                       w_slot;

    // A pop is exactly a cycle where the FIFO is being strobed.
    assign w_pop  = ren_o;
    assign w_last = (r_count == LAST_CNT);

`ifdef FC_INPUT_REVERSE_EN
    assign w_slot = LAST_CNT - r_count;
`else
    assign w_slot = r_count;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL: if (w_pop && w_last) w_next_state = S_FULL;
            S_FULL: if (yumi_i)          w_next_state = S_FILL;
            default:                     w_next_state = S_FILL;
        endcase
    end

    // Output logic; reset gates ren_o so nothing is popped while reset is held.
    always_comb begin
        ren_o   = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            S_FILL: ren_o   = ~empty_i & ~reset_i;
            S_FULL: valid_o = 1'b1;
            default: begin
                ren_o   = 1'b0;
                valid_o = 1'b0;
            end
        endcase
    end

    // Slot counter wraps to 0 on the last pop so the next pass starts cleanly.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (w_pop) begin
            if (w_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Only the addressed slot is written; untouched slots keep stale words.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data <= '0;
        end else if (w_pop) begin
            r_data[w_slot] <= data_i;
        end
    end

    assign data_o = r_data;

endmodule

// File: tb/tb_fc_input_layer.sv
module tb_fc_input_layer;

    localparam int LH = 4;
    localparam int WS = 16;

    logic                    clk_i = 1'b0;
    logic                    reset_i = 1'b1;
    logic [WS-1:0]           data_i = '0;
    logic                    empty_i = 1'b1;
    logic                    ren_o;
    logic [LH-1:0][WS-1:0]   data_o;
    logic                    valid_o;
    logic                    yumi_i = 1'b0;

    fc_input_layer #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .empty_i (empty_i),
        .ren_o   (ren_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ren   = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words of the current pass collected in a queue; when the
    // pass is complete the expected vector is laid out in one go.
    logic [WS-1:0]         mdl_q[$];
    bit                    mdl_full = 1'b0;
    logic [LH-1:0][WS-1:0] mdl_vec = '0;

    always @(posedge clk_i) begin
        if (reset_i) begin
            mdl_full = 1'b0;
            mdl_q.delete();
        end else if (mdl_full) begin
            if (yumi_i) mdl_full = 1'b0;
        end else if (!empty_i) begin
            mdl_q.push_back(data_i);
            if (mdl_q.size() == LH) begin
                for (int k = 0; k < LH; k++) begin
`ifdef FC_INPUT_REVERSE_EN
                    mdl_vec[LH-1-k] = mdl_q[k];
`else
                    mdl_vec[k] = mdl_q[k];
`endif
                end
                mdl_full = 1'b1;
                mdl_q.delete();
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk_i) begin
        if (ren_o === 1'b1) n_ren++;
        if (started) begin
            chk("ren_o", 64'(ren_o), 64'(!reset_i && !mdl_full && !empty_i));
            chk("valid_o", 64'(valid_o), 64'(mdl_full));
            if (mdl_full) chk("data_o", 64'(data_o), 64'(mdl_vec));
        end
    end

    // Hand-computed vector; a0 is the first word popped.
    function automatic logic [63:0] vec4(input logic [15:0] a0, a1, a2, a3);
`ifdef FC_INPUT_REVERSE_EN
        return {a0, a1, a2, a3};
`else
        return {a3, a2, a1, a0};
`endif
    endfunction

    task automatic step(input logic rst, input logic emp, input logic [15:0] d, input logic y);
        reset_i = rst;
        empty_i = emp;
        data_i  = d;
        yumi_i  = y;
        @(posedge clk_i);
        #1;
    endtask

    int r0;
    logic [63:0] held;

    initial begin
        step(1, 1, 16'h0, 0);
        started = 1'b1;
        step(1, 0, 16'hdead, 0);
        chk("reset data_o", 64'(data_o), 64'h0);
        chk("reset valid_o", 64'(valid_o), 64'h0);

        // back-to-back fill
        r0 = n_ren;
        step(0, 0, 16'h0001, 0);
        step(0, 0, 16'h0002, 0);
        step(0, 0, 16'h0003, 0);
        step(0, 0, 16'h0004, 0);
        chk("b2b pops", 64'(n_ren - r0), 64'd4);
        chk("b2b valid", 64'(valid_o), 64'd1);
        chk("b2b data", 64'(data_o), vec4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
        chk("b2b ren after", 64'(ren_o), 64'd0);

        // held output for 10 cycles
        held = 64'(data_o);
        r0 = n_ren;
        for (int i = 0; i < 10; i++) step(0, 0, 16'hbeef, 0);
        chk("held pops", 64'(n_ren - r0), 64'd0);
        chk("held data", 64'(data_o), held);
        step(0, 0, 16'h0005, 1);
        chk("yumi valid drop", 64'(valid_o), 64'd0);
        chk("yumi ren resume", 64'(ren_o), 64'd1);

        // second vector, yumi still high during fill (ignored)
        step(0, 0, 16'h0011, 1);
        step(0, 0, 16'h0012, 0);
        step(0, 0, 16'h0013, 0);
        step(0, 0, 16'h0014, 0);
        chk("vec2 data", 64'(data_o), vec4(16'h0011, 16'h0012, 16'h0013, 16'h0014));
        // immediate yumi, next vector right behind it
        step(0, 0, 16'h0099, 1);
        step(0, 0, 16'h0021, 0);
        step(0, 0, 16'h0022, 0);
        step(0, 0, 16'h0023, 0);
        step(0, 0, 16'h0024, 0);
        chk("vec3 data", 64'(data_o), vec4(16'h0021, 16'h0022, 16'h0023, 16'h0024));
        step(0, 1, 16'h0, 1);

        // stalled fill
        r0 = n_ren;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 16'h5555, 0);
            chk("stall valid early", 64'(valid_o), 64'd0);
            step(0, 0, 16'hA000 + 16'(i), 0);
        end
        chk("stall pops", 64'(n_ren - r0), 64'd4);
        chk("stall valid", 64'(valid_o), 64'd1);
        chk("stall data", 64'(data_o), vec4(16'hA000, 16'hA001, 16'hA002, 16'hA003));
        step(0, 1, 16'h0, 1);

        // reset mid-fill
        step(0, 0, 16'h1111, 0);
        step(0, 0, 16'h2222, 0);
        step(1, 0, 16'h3333, 1);
        chk("midrst data", 64'(data_o), 64'h0);
        chk("midrst valid", 64'(valid_o), 64'd0);
        for (int i = 5; i <= 8; i++) step(0, 0, 16'(i), 0);
        chk("postrst data", 64'(data_o), vec4(16'h0005, 16'h0006, 16'h0007, 16'h0008));
        chk("postrst valid", 64'(valid_o), 64'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) == 0),
                 16'($urandom),
                 (mdl_full && ($urandom_range(0, 2) == 0)));
        end

        step(1, 1, 16'h0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
